// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BHT of 2-bit saturating counters with a tagged BTB.
// Lookup is combinational on if_pc; resolved branches from EX update the table on the clock edge.
module branch_predictor #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned STAT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   if_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [XLEN-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [XLEN-1:0]   upd_pred_target,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [STAT_W-1:0] stat_branches_q;
    logic [STAT_W-1:0] stat_mispredicts_q;

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    // Instruction alignment bits never take part in indexing or tagging.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{if_pc[1:0], upd_pc[1:0]};

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[XLEN-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX_W+2];

    always_comb begin
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = if_hit && ctr_q[if_idx][1];
        pred_target = pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);
    end

    always_comb begin
        upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        // A not-taken branch predicted not-taken is correct regardless of the carried target.
        mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                    (upd_taken && (upd_target != upd_pred_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '{default: 1'b0};
            tag_q    <= '{default: '0};
            target_q <= '{default: '0};
            ctr_q    <= '{default: 2'b01};
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx] != 2'b11) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
                    end
                    target_q[upd_idx] <= upd_target;
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= 2'b10;
            end
        end
    end

    // Statistics saturate at all-ones so long runs never wrap back to small values.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (upd_valid && (stat_branches_q != '1)) begin
                stat_branches_q <= stat_branches_q + STAT_W'(1);
            end
            if (mispredict && (stat_mispredicts_q != '1)) begin
                stat_mispredicts_q <= stat_mispredicts_q + STAT_W'(1);
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised IF-stage branch predictor (direct-mapped BHT of 2-bit saturating counters plus a tagged BTB) for the next-generation pipelined core. It replaces "always predict PC+4, resolve in MEM" with a same-cycle taken/target prediction at fetch. It accepts resolved-branch updates from EX. It generates the mispredict/redirect signal that drives the IF/ID and ID/EX flush. Per-run branch and mispredict statistics are kept for benchmarking.

## Interface
- XLEN, 64, address/data width.
- ENTRIES, 16, table depth; power of two, 2..1024.
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden).
- TAG_W, XLEN-IDX_W-2, stored tag width = pc[XLEN-1:IDX_W+2].
- STAT_W, 32, width of statistics counters.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- if_pc  in  XLEN  fetch PC (from pc register).
- pred_taken  out  1  predicted taken for if_pc (combinational).
- pred_target  out  XLEN  predicted next PC: BTB target if pred_taken, else if_pc+4.
- upd_valid  in  1  EX stage holds a resolved conditional branch this cycle.
- upd_pc  in  XLEN  PC of that branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual taken target (pc+imm<<1).
- upd_pred_taken  in  1  prediction made for this branch, carried down the pipe.
- upd_pred_target  in  XLEN  predicted next PC carried down the pipe.
- mispredict  out  1  prediction wrong; flush IF/ID and ID/EX, load redirect_pc.
- redirect_pc  out  XLEN  correct next PC: upd_taken ? upd_target : upd_pc+4.
- stat_branches  out  STAT_W  resolved branches since reset.
- stat_mispredicts  out  STAT_W  mispredicts since reset.

## Operation
- Per entry: valid (1), tag (TAG_W), target (XLEN), ctr (2). Index = pc[IDX_W+1:2]; pc[1:0] ignored.
- Lookup: hit = valid[i] && tag[i]==if_pc[XLEN-1:IDX_W+2]; pred_taken = hit && ctr[i][1]; pred_target = pred_taken ? target[i] : if_pc+4 (XLEN wrap, no carry out).
- Resolve (combinational, gated by upd_valid): mispredict = upd_valid && (upd_taken!=upd_pred_taken || upd_taken && upd_target!=upd_pred_target). Not-taken branch predicted not-taken is never a mispredict, whatever upd_pred_target holds. mispredict=0 when upd_valid=0.
- Update on rising edge with upd_valid=1, index/tag from upd_pc:
  - Hit: ctr saturating +1 if taken (max 3), -1 if not taken (min 0). Target overwritten with upd_target when taken.
  - Miss, taken: allocate/replace: valid=1, tag, target=upd_target, ctr=2 (weakly taken).
  - Miss, not taken: no table change.
- Stats: stat_branches +1 per upd_valid cycle; stat_mispredicts +1 per mispredict cycle. Both saturate at all-ones and never wrap.
- Counter encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.

## Timing
- Reset (synchronous): all valid=0, ctr=1, tag/target=0, stats=0. While reset is high, updates are ignored. First edge after reset deasserts accepts updates.
- Reset-derived outputs: pred_taken=0; pred_target=if_pc+4; mispredict follows inputs combinationally and is only meaningful when upd_valid=1.
- Lookup latency 0 cycles (combinational on if_pc). Update effective from the cycle after the upd_valid edge.
- Same-index lookup and update in one cycle: lookup returns pre-update contents (read-before-write, no bypass).
- Aliasing: two PCs with the same index and different tags replace each other on taken allocation. A not-taken miss never evicts.
- mispredict/redirect_pc are combinational in the upd_valid cycle. The consumer registers the PC redirect at that edge, giving a 2-cycle penalty (IF/ID and ID/EX flushed).
- No handshake: upd_valid is a single-cycle qualifier and may be asserted on consecutive cycles.

## Test plan
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104; stats=0.
- upd_valid pc=0x100 taken target=0x80 pred_taken=0 -> mispredict=1, redirect_pc=0x80, stat_mispredicts=1. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80.
- Same branch 3x not taken -> ctr 2->1->0->0 (saturates); pred_taken=0 after the first. Then taken x2 -> pred_taken=1 only after the second.
- ENTRIES=16: allocate taken 0x100 (index 0), then taken 0x140 (index 0, new tag) -> 0x100 misses (pred 0x104), 0x140 predicts its target. A not-taken miss at 0x180 leaves 0x140 intact.
- upd_valid taken with pred_taken=1 but upd_pred_target=0x90 vs upd_target=0x80 -> mispredict=1, redirect 0x80. Not-taken with pred not-taken -> mispredict=0.
- Update and lookup at the same index in the same cycle -> old prediction; reset asserted mid-stream alongside upd_valid -> table and stats cleared, update dropped. Force stat counters to all-ones (STAT_W=4, 20 updates) -> hold at 15.
